keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter N_KEYS, default 10, number of one-hot key inputs (legal range 2..64).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8, number of consecutive stable clk cycles required to accept a press or a release (legal range 1..255).
REQ-003 Parameter DIV, default 100, clk cycles per tick period (legal range 2..65535).
REQ-004 Parameter REPEAT_DELAY, default 5, ticks a key is held before auto-repeat starts; 0 disables repeat.
REQ-005 Parameter REPEAT_RATE, default 2, ticks between auto-repeat pulses (legal range 1..255).
REQ-006 Localparam CODE_W SHALL equal max(1, clog2(N_KEYS)).
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 keys  input  N_KEYS  raw key levels, 1 = pressed, asynchronous to clk.
REQ-010 enable  input  1  1 = encoding allowed; 0 = encoder idle.
REQ-011 code  output  CODE_W  index of the last accepted key.
REQ-012 loadn  output  1  active-low, one-cycle strobe: code is valid to load.
REQ-013 tick  output  1  one-cycle pulse every DIV clk cycles.
REQ-014 multi_err  output  1  the last accepted press had more than one key active.

Function
REQ-015 keys SHALL pass through a two-flop synchroniser; all decisions use the synchronised value.
REQ-016 The candidate key SHALL be the lowest-indexed active synchronised key (priority encode).
REQ-017 The tick counter SHALL run 0..DIV-1 freely, independent of enable; tick = 1 in the cycle the counter wraps from DIV-1 to 0.
REQ-018 FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
REQ-019 IDLE: if enable = 1 and any key is active, latch the candidate, clear the debounce counter, and go to DEBOUNCE.
REQ-020 DEBOUNCE: if the candidate is unchanged, increment the counter; on the DEBOUNCE_CYCLES-th consecutive match, drive loadn = 0 for one cycle, update code in that same cycle, set multi_err to (popcount > 1), and go to HELD.
REQ-021 DEBOUNCE: if the candidate changes or no key is active, return to IDLE with the counter cleared and no strobe.
REQ-022 HELD: count ticks while the latched key stays active; after REPEAT_DELAY ticks, and then every REPEAT_RATE ticks, pulse loadn = 0 for one cycle with code unchanged (only when REPEAT_DELAY != 0).
REQ-023 HELD: if the latched key goes inactive, go to RELEASE with the counter cleared; keys pressed while in HELD are ignored.
REQ-024 RELEASE: after DEBOUNCE_CYCLES consecutive cycles with no key active, go to IDLE; any active key restarts the count.
REQ-025 enable = 0 in any state: next state is IDLE, all counters except the tick counter clear, loadn = 1; code and multi_err hold their values.
REQ-026 loadn SHALL never be low in two consecutive cycles.
REQ-027 code and multi_err SHALL change only in a cycle where loadn = 0 from REQ-020.
REQ-028 If the tick wrap and the debounce acceptance fall in the same cycle, the acceptance SHALL proceed normally; the repeat tick count in HELD starts from the next tick.

Reset
REQ-029 rst = 1 SHALL force state = IDLE, code = 0, loadn = 1, tick = 0, multi_err = 0, and clear all counters and synchroniser flops.
REQ-030 A reset asserted mid-press SHALL discard the press; after release of rst, a press still held SHALL be re-debounced from zero.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 The tick generator SHALL be a sub-module tick_divider (parameter DIV; ports clk, rst, tick).

Verification
REQ-033 N_KEYS = 10, DEBOUNCE_CYCLES = 8: hold keys[7] for 20 cycles -> exactly one loadn pulse, 8 cycles after the synchronised rise; code = 7; multi_err = 0.
REQ-034 Bounce keys[3] high for 5 cycles, low for 1 cycle, then high for 10 cycles -> one loadn pulse only, after the second rise, with code = 3.
REQ-035 Press keys[2] and keys[6] together -> code = 2, multi_err = 1; a later clean press of keys[4] -> code = 4, multi_err = 0.
REQ-036 DIV = 10, REPEAT_DELAY = 5, REPEAT_RATE = 2: hold keys[1] for 200 cycles -> first strobe, then repeats about 50 cycles later and every 20 cycles after that.
REQ-037 Drop enable in HELD -> no further strobes and state = IDLE; raise enable again with the key still held -> one new strobe after the debounce period.
REQ-038 Assert rst during DEBOUNCE -> no strobe, outputs match reset values, and tick restarts its count from 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad encoder: the controller state encoding and
// the default values of the encoder parameters.
// -----------------------------------------------------------------------------
package keypad_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Default parameter values
  localparam int KP_N_KEYS          = 10;
  localparam int KP_DEBOUNCE_CYCLES = 8;
  localparam int KP_DIV             = 100;
  localparam int KP_REPEAT_DELAY    = 5;
  localparam int KP_REPEAT_RATE     = 2;

endpackage : keypad_pkg

// File: rtl/keypad_encoder_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running modulo-DIV counter producing a one-cycle tick pulse.
// The counter runs 0..DIV-1; tick is high in the cycle the count has just
// wrapped from DIV-1 back to 0.
//
// Ports
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   tick out  registered one-cycle pulse every DIV clk cycles
// -----------------------------------------------------------------------------
module tick_divider
  import keypad_pkg::*;
#(
  parameter int DIV = KP_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Next count and tick: wrap at DIV-1 and flag the wrap
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
    end
  end

  // Counter and registered tick output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : tick_divider

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Debounced priority encoder for a one-hot keypad with auto-repeat.
// Raw keys are synchronised with two flops; the lowest-indexed active key is
// the candidate. A candidate that stays stable for DEBOUNCE_CYCLES cycles is
// accepted: code is updated and loadn pulses low for one cycle. While the key
// stays held, further loadn pulses are generated after REPEAT_DELAY ticks and
// then every REPEAT_RATE ticks. A release must also be stable for
// DEBOUNCE_CYCLES cycles before a new press is considered.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   keys      in   raw key levels (1 = pressed), asynchronous to clk
//   enable    in   1 = encoding allowed, 0 = controller held idle
//   code      out  index of the last accepted key
//   loadn     out  active-low one-cycle strobe, code valid to load
//   tick      out  one-cycle pulse every DIV clk cycles
//   multi_err out  last accepted press had more than one key active
// -----------------------------------------------------------------------------
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = KP_N_KEYS,
  parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int DIV             = KP_DIV,
  parameter int REPEAT_DELAY    = KP_REPEAT_DELAY,
  parameter int REPEAT_RATE     = KP_REPEAT_RATE,
  localparam int CODE_W         = (N_KEYS > 2) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  input  logic              enable,
  output logic [CODE_W-1:0] code,
  output logic              loadn,
  output logic              tick,
  output logic              multi_err
);

  // The IDLE cycle that latches the candidate is the first stable cycle, so
  // DEBOUNCE only needs DEBOUNCE_CYCLES-1 further matches (at least one).
  localparam logic [7:0] DEB_LAST = (DEBOUNCE_CYCLES > 1) ? 8'(DEBOUNCE_CYCLES - 2) : 8'd0;
  localparam logic [7:0] REL_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] RD_LAST  = (REPEAT_DELAY > 0) ? 8'(REPEAT_DELAY - 1) : 8'd0;
  localparam logic [7:0] RR_LAST  = 8'(REPEAT_RATE - 1);
  localparam logic       REPEAT_EN = (REPEAT_DELAY != 0);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] keys_s;
  logic [CODE_W-1:0] cand_s;
  logic              any_s;
  logic              multi_s;
  logic              held_s;
  logic              tick_s;

  kp_state_e         state_q;
  logic [CODE_W-1:0] cand_q;
  logic [7:0]        deb_cnt_q;
  logic [7:0]        rep_cnt_q;
  logic              repeating_q;
  logic [CODE_W-1:0] code_q;
  logic              loadn_q;
  logic              multi_q;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign keys_s = sync2_q;
  assign any_s  = |keys_s;
  assign held_s = keys_s[cand_q];
  // Clearing the lowest set bit leaves something only if two or more are set
  assign multi_s = |(keys_s & (keys_s - {{(N_KEYS-1){1'b0}}, 1'b1}));

  // Priority encoder: scan downwards so the lowest active index wins
  always_comb begin
    cand_s = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      cand_s = keys_s[i] ? CODE_W'(i) : cand_s;
    end
  end

  // Input synchroniser and press/hold/release controller with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      deb_cnt_q   <= 8'd0;
      rep_cnt_q   <= 8'd0;
      repeating_q <= 1'b0;
      code_q      <= '0;
      loadn_q     <= 1'b1;
      multi_q     <= 1'b0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      loadn_q <= 1'b1;
      if (!enable) begin
        state_q     <= ST_IDLE;
        deb_cnt_q   <= 8'd0;
        rep_cnt_q   <= 8'd0;
        repeating_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (any_s) begin
              cand_q    <= cand_s;
              deb_cnt_q <= 8'd0;
              state_q   <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (any_s && (cand_s == cand_q)) begin
              if (deb_cnt_q >= DEB_LAST) begin
                loadn_q     <= 1'b0;
                code_q      <= cand_q;
                multi_q     <= multi_s;
                deb_cnt_q   <= 8'd0;
                rep_cnt_q   <= 8'd0;
                repeating_q <= 1'b0;
                state_q     <= ST_HELD;
              end else begin
                deb_cnt_q <= deb_cnt_q + 8'd1;
              end
            end else begin
              deb_cnt_q <= 8'd0;
              state_q   <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (!held_s) begin
              deb_cnt_q   <= 8'd0;
              rep_cnt_q   <= 8'd0;
              repeating_q <= 1'b0;
              state_q     <= ST_RELEASE;
            end else if (REPEAT_EN && tick_s) begin
              // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE
              if (rep_cnt_q >= (repeating_q ? RR_LAST : RD_LAST)) begin
                loadn_q     <= 1'b0;
                rep_cnt_q   <= 8'd0;
                repeating_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + 8'd1;
              end
            end
          end
          ST_RELEASE: begin
            if (any_s) begin
              deb_cnt_q <= 8'd0;
            end else if (deb_cnt_q >= REL_LAST) begin
              deb_cnt_q <= 8'd0;
              state_q   <= ST_IDLE;
            end else begin
              deb_cnt_q <= deb_cnt_q + 8'd1;
            end
          end
          default: begin
            deb_cnt_q   <= 8'd0;
            rep_cnt_q   <= 8'd0;
            repeating_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign code      = code_q;
  assign loadn     = loadn_q;
  assign multi_err = multi_q;
  assign tick      = tick_s;

endmodule : keypad_encoder

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
// Directed bench for keypad_encoder (N_KEYS=10, DEBOUNCE_CYCLES=8, DIV=10,
// REPEAT_DELAY=5, REPEAT_RATE=2). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. Edge index 1 is the first
// rising edge after a change of stimulus.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;
  import keypad_pkg::*;

  localparam int N_KEYS = 10;
  localparam int CODE_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [N_KEYS-1:0] keys;
  logic [CODE_W-1:0] code;
  logic              loadn;
  logic              tick;
  logic              multi_err;

  int n_vec  = 0;
  int n_fail = 0;
  logic prev_low = 1'b0;

  int pidx [16];
  int np;
  int first_idx;
  int tfirst;
  int tcount;

  typedef struct {
    logic [N_KEYS-1:0] keys;
    logic              en;
    int                hold;
    int                exp_np;
    int                exp_first;
    int                exp_code;
    int                exp_multi;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  keypad_encoder #(
    .N_KEYS          (10),
    .DEBOUNCE_CYCLES (8),
    .DIV             (10),
    .REPEAT_DELAY    (5),
    .REPEAT_RATE     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .enable    (enable),
    .code      (code),
    .loadn     (loadn),
    .tick      (tick),
    .multi_err (multi_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: wait for the edge, settle, then watch for back-to-back strobes
  task automatic step();
    @(posedge clk);
    #1;
    if (!loadn) begin
      check("loadn_not_consecutive", 32'(prev_low), 32'd0);
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  endtask

  // Run total edges; raw keys are released after edge 'hold' (hold < 0: never)
  task automatic run_window(input int total, input int hold);
    np = 0;
    first_idx = 0;
    tfirst = 0;
    tcount = 0;
    for (int i = 1; i <= total; i++) begin
      if (i == hold + 1) keys = '0;
      step();
      if (!loadn) begin
        if (np < 16) pidx[np] = i;
        np++;
        if (first_idx == 0) first_idx = i;
      end
      if (tick) begin
        tcount++;
        if (tfirst == 0) tfirst = i;
      end
    end
  endtask

  initial begin
    //             keys        en    hold np first code multi
    vecs[0]  = '{10'h080, 1'b1, 20, 1, 10, 7, 0};
    vecs[1]  = '{10'h044, 1'b1, 20, 1, 10, 2, 1};
    vecs[2]  = '{10'h010, 1'b1, 20, 1, 10, 4, 0};
    vecs[3]  = '{10'h001, 1'b1, 20, 1, 10, 0, 0};
    vecs[4]  = '{10'h200, 1'b1, 20, 1, 10, 9, 0};
    vecs[5]  = '{10'h3FF, 1'b1, 20, 1, 10, 0, 1};
    vecs[6]  = '{10'h020, 1'b1,  7, 0,  0, 0, 1};
    vecs[7]  = '{10'h020, 1'b1,  8, 1, 10, 5, 0};
    vecs[8]  = '{10'h008, 1'b0, 20, 0,  0, 5, 0};
    vecs[9]  = '{10'h0C0, 1'b1, 20, 1, 10, 6, 1};
    vecs[10] = '{10'h100, 1'b1, 20, 1, 10, 8, 0};

    rst = 1'b1;
    enable = 1'b1;
    keys = '0;
    #1;
    check("reset_code", 32'(code), 32'd0);
    check("reset_loadn", 32'(loadn), 32'd1);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_multi", 32'(multi_err), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Tick period from reset release
    run_window(25, -1);
    check("tick_first_edge", 32'(tfirst), 32'd10);
    check("tick_count_25", 32'(tcount), 32'd2);

    // Table of single presses
    for (int v = 0; v < 11; v++) begin
      keys = vecs[v].keys;
      enable = vecs[v].en;
      run_window(vecs[v].hold + 16, vecs[v].hold);
      check($sformatf("vec%0d_pulses", v), 32'(np), 32'(vecs[v].exp_np));
      check($sformatf("vec%0d_latency", v), 32'(first_idx), 32'(vecs[v].exp_first));
      check($sformatf("vec%0d_code", v), 32'(code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d_multi", v), 32'(multi_err), 32'(vecs[v].exp_multi));
      enable = 1'b1;
    end

    // Bounce: high 5, low 1, high 10 on keys[3]
    np = 0;
    first_idx = 0;
    for (int i = 1; i <= 30; i++) begin
      keys = ((i <= 5) || (i >= 7 && i <= 16)) ? 10'h008 : 10'h000;
      step();
      if (!loadn) begin
        np++;
        if (first_idx == 0) first_idx = i;
      end
    end
    check("bounce_pulses", 32'(np), 32'd1);
    check("bounce_latency", 32'(first_idx), 32'd16);
    check("bounce_code", 32'(code), 32'd3);
    check("bounce_multi", 32'(multi_err), 32'd0);

    // Auto-repeat on keys[1] held for 200 cycles
    keys = 10'h002;
    run_window(216, 200);
    check("repeat_enough_pulses", 32'(np >= 4), 32'd1);
    check("repeat_first", 32'(pidx[0]), 32'd10);
    check("repeat_delay_window", 32'((pidx[1] - pidx[0]) >= 41 && (pidx[1] - pidx[0]) <= 50), 32'd1);
    check("repeat_rate_1", 32'(pidx[2] - pidx[1]), 32'd20);
    check("repeat_rate_2", 32'(pidx[3] - pidx[2]), 32'd20);
    check("repeat_code", 32'(code), 32'd1);

    // Enable dropped while held, then restored with key still down
    keys = 10'h100;
    run_window(15, -1);
    check("en_press_latency", 32'(first_idx), 32'd10);
    enable = 1'b0;
    run_window(80, -1);
    check("en_off_pulses", 32'(np), 32'd0);
    check("en_off_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("en_off_code", 32'(code), 32'd8);
    enable = 1'b1;
    run_window(12, -1);
    check("en_on_pulses", 32'(np), 32'd1);
    check("en_on_latency", 32'(first_idx), 32'd8);
    keys = '0;
    run_window(16, -1);

    // Reset in the middle of debouncing keys[6]
    keys = 10'h040;
    run_window(5, -1);
    check("rst_pre_pulses", 32'(np), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_code", 32'(code), 32'd0);
    check("rst_mid_loadn", 32'(loadn), 32'd1);
    check("rst_mid_tick", 32'(tick), 32'd0);
    check("rst_mid_multi", 32'(multi_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    run_window(14, -1);
    check("rst_tick_restart", 32'(tfirst), 32'd10);
    check("rst_redebounce_latency", 32'(first_idx), 32'd10);
    check("rst_redebounce_code", 32'(code), 32'd6);
    keys = '0;
    run_window(16, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_keypad_encoder
